mfsc_pingpong_buffer: RTL

// Parametrised double-buffered feature-map ingest controller between the log10/MFSC stream and the ShuffleNet core.

---
 rtl/mfsc_pingpong_buffer_if.sv | 29 ++
 rtl/mfsc_pingpong_buffer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mfsc_pingpong_buffer_if.sv
// Bundles the sample ingest handshake, BRAM write port and CNN hand-off
// signals of the ping/pong feature-map buffer.
interface mfsc_pingpong_buffer_if #(
  parameter int DATA_W = 16,
  parameter int BUS_W  = 64,
  parameter int ADDR_W = 9
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              wr_en;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [BUS_W-1:0]  wr_data;
  logic              fm_ready;
  logic              fm_bank;
  logic              fm_done;
  logic [15:0]       drop_cnt;

  modport master (
    output in_valid, in_data, fm_done,
    input  in_ready, wr_en, wr_bank, wr_addr, wr_data, fm_ready, fm_bank, drop_cnt
  );

  modport slave (
    input  in_valid, in_data, fm_done,
    output in_ready, wr_en, wr_bank, wr_addr, wr_data, fm_ready, fm_bank, drop_cnt
  );
endinterface

// File: rtl/mfsc_pingpong_buffer.sv
// Double-buffered MFSC feature-map ingest: packs samples into BRAM words,
// fills banks A/B alternately and hands each finished map to the CNN.
module mfsc_pingpong_buffer #(
  parameter int DATA_W       = 16,
  parameter int BUS_W        = 64,
  parameter int N_COEF       = 40,
  parameter int N_FRAMES     = 32,
  parameter int ADDR_W       = 9,
  parameter int DROP_ON_FULL = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  mfsc_pingpong_buffer_if.slave  bus
);

  localparam int LANES  = BUS_W / DATA_W;
  localparam int WORDS  = (N_COEF * N_FRAMES) / LANES;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

  logic [1:0]        full_q, full_d;
  logic              wb_q, wb_d;
  logic              rb_q, rb_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BUS_W-1:0]  pack_q, pack_d;
  logic              pend_q, pend_d;
  logic              wr_en_q, wr_en_d;
  logic              wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [BUS_W-1:0]  wr_data_q, wr_data_d;
  logic [15:0]       drop_q, drop_d;

  logic              in_ready_s;
  logic              take_s;
  logic              drop_s;
  logic              release_s;
  logic              tgt_bank_s;
  logic [ADDR_W-1:0] tgt_addr_s;
  logic [BUS_W-1:0]  merged_s;

  // Handshake decode; pend_q marks the cycle between the last word of a map and its hand-off.
  always_comb begin
    in_ready_s = (DROP_ON_FULL != 0) ? 1'b1 : ~full_q[wb_q];
    take_s     = bus.in_valid & in_ready_s & ~full_q[wb_q];
    drop_s     = bus.in_valid & in_ready_s & full_q[wb_q] & (DROP_ON_FULL != 0);
    release_s  = bus.fm_done & full_q[rb_q];
    tgt_bank_s = pend_q ? ~wb_q : wb_q;
    tgt_addr_s = pend_q ? {ADDR_W{1'b0}} : addr_q;
  end

  // Next-state: lane packing, word writes, map completion, CNN release and drop counting.
  always_comb begin
    full_d    = full_q;
    wb_d      = wb_q;
    rb_d      = rb_q;
    lane_d    = lane_q;
    addr_d    = addr_q;
    pack_d    = pack_q;
    pend_d    = 1'b0;
    wr_en_d   = 1'b0;
    wr_bank_d = wr_bank_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    drop_d    = drop_q;
    merged_s  = pack_q;
    merged_s[lane_q*DATA_W +: DATA_W] = bus.in_data;

    if (flush) begin
      full_d    = 2'b00;
      wb_d      = 1'b0;
      rb_d      = 1'b0;
      lane_d    = {LANE_W{1'b0}};
      addr_d    = {ADDR_W{1'b0}};
      pack_d    = {BUS_W{1'b0}};
      wr_bank_d = 1'b0;
      wr_addr_d = {ADDR_W{1'b0}};
      wr_data_d = {BUS_W{1'b0}};
      drop_d    = 16'd0;
    end else begin
      // The bank is marked full only after its last write has landed.
      if (pend_q) begin
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
        addr_d       = {ADDR_W{1'b0}};
      end else begin
        addr_d = addr_q;
      end

      if (take_s) begin
        if (lane_q == LAST_LANE) begin
          lane_d    = {LANE_W{1'b0}};
          pack_d    = {BUS_W{1'b0}};
          wr_en_d   = 1'b1;
          wr_bank_d = tgt_bank_s;
          wr_addr_d = tgt_addr_s;
          wr_data_d = merged_s;
          if (tgt_addr_s == LAST_ADDR) begin
            pend_d = 1'b1;
          end else begin
            addr_d = tgt_addr_s + ADDR_W'(1);
          end
        end else begin
          lane_d = lane_q + LANE_W'(1);
          pack_d = merged_s;
        end
      end else if (drop_s && (drop_q != 16'hFFFF)) begin
        drop_d = drop_q + 16'd1;
      end else begin
        drop_d = drop_q;
      end

      if (release_s) begin
        full_d[rb_q] = 1'b0;
        rb_d         = ~rb_q;
      end else begin
        rb_d = rb_q;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q    <= 2'b00;
      wb_q      <= 1'b0;
      rb_q      <= 1'b0;
      lane_q    <= {LANE_W{1'b0}};
      addr_q    <= {ADDR_W{1'b0}};
      pack_q    <= {BUS_W{1'b0}};
      pend_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_bank_q <= 1'b0;
      wr_addr_q <= {ADDR_W{1'b0}};
      wr_data_q <= {BUS_W{1'b0}};
      drop_q    <= 16'd0;
    end else begin
      full_q    <= full_d;
      wb_q      <= wb_d;
      rb_q      <= rb_d;
      lane_q    <= lane_d;
      addr_q    <= addr_d;
      pack_q    <= pack_d;
      pend_q    <= pend_d;
      wr_en_q   <= wr_en_d;
      wr_bank_q <= wr_bank_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.in_ready = in_ready_s;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_bank  = wr_bank_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.fm_ready = full_q[rb_q];
  assign bus.fm_bank  = rb_q;
  assign bus.drop_cnt = drop_q;

endmodule
